// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts out one byte with odd parity and stop bit on device clocks, then
// checks the device line-ack before returning to idle.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE,
    FAIL
  } state_t;

  state_t           state;
  logic [9:0]       frame;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  tout_cnt;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic clk_fall;
  logic timed_out;

  // Two-flop synchronizers for the raw bus lines plus a delayed copy of the
  // synced clock for falling-edge detection; idle bus level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  // Falling-edge strobe and timeout condition for the device-clocked phases.
  always_comb begin
    clk_fall  = clk_prev & ~clk_sync;
    timed_out = ((state == SEND) || (state == ACK) || (state == WAIT_IDLE)) &&
                (tout_cnt == TO_LIMIT);
  end

  // Transmit sequencer with registered bus-drive and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      tout_cnt    <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (timed_out) begin
        state       <= FAIL;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        busy        <= 1'b0;
        tx_error    <= 1'b1;
      end else begin
        unique case (state)
          // DONE and FAIL already show busy low, so a start there is honoured
          // just as in IDLE rather than being silently dropped.
          IDLE, DONE, FAIL: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= IDLE;
            if (tx_start) begin
              frame      <= {1'b1, ~^tx_byte, tx_byte};
              inh_cnt    <= '0;
              bit_cnt    <= '0;
              ps2_clk_oe <= 1'b1;
              busy       <= 1'b1;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_data_oe <= 1'b1;
              state       <= REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          REQ: begin
            ps2_clk_oe <= 1'b0;
            tout_cnt   <= '0;
            bit_cnt    <= '0;
            state      <= SEND;
          end
          SEND: begin
            tout_cnt <= tout_cnt + 1'b1;
            if (clk_fall) begin
              ps2_data_oe <= ~frame[bit_cnt];
              if (bit_cnt == 4'd9) begin
                state <= ACK;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ACK: begin
            tout_cnt <= tout_cnt + 1'b1;
            if (clk_fall) begin
              if (!data_sync) begin
                state <= WAIT_IDLE;
              end else begin
                state       <= FAIL;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                busy        <= 1'b0;
                tx_error    <= 1'b1;
              end
            end
          end
          WAIT_IDLE: begin
            tout_cnt <= tout_cnt + 1'b1;
            if (clk_sync && data_sync) begin
              state   <= DONE;
              busy    <= 1'b0;
              tx_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
